ripple_count_ctrl: RTL and testbench

Measurement sequencer for the 4-bit asynchronous ripple counter. The counter's input clock is an event/pulse source gated by this block. The block:
- clears the counter,
- opens a gate window of programmable length,
- closes the gate and waits for ripple propagation to settle,
- samples the count safely in the clk domain,
- returns the result over a valid/ready handshake.

It sits between the control/CSR logic and the ripple counter instance.

---
 rtl/ripple_count_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ripple_count_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_ctrl.sv
// Measurement sequencer for a 4-bit asynchronous ripple counter: clear, gate, settle, double-sample, report.
// Optional abort input is enabled by defining RIPPLE_CTRL_ABORT_EN.
module ripple_count_ctrl #(
  parameter int WIDTH     = 4,
  parameter int WIN_W     = 8,
  parameter int SETTLE    = 3,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic             ctr_clr,
  output logic             gate_en,
  input  logic [WIDTH-1:0] ctr_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_count,
  output logic             res_ovf,
  output logic             res_err,
`ifdef RIPPLE_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic [2:0]       fsm_state
);

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_GATE, ST_SETTLE, ST_SAMP_A, ST_SAMP_B, ST_DONE
  } state_t;

  state_t           state;
  logic [WIN_W-1:0] win_len;
  logic [WIN_W-1:0] win_cnt;
  logic [SW-1:0]    set_cnt;
  logic [RW-1:0]    retry;
  logic             clr_cnt;
  logic [WIDTH-1:0] samp_a;
  logic             ovf;
  logic             msb_s1, msb_s2, msb_s3;

  assign fsm_state = state;

  // Result handshake: res_valid rises on entry to DONE and holds with a stable
  // payload until a cycle where res_valid & res_ready; it drops on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      ctr_clr   <= 1'b1;
      gate_en   <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
      win_len   <= '0;
      win_cnt   <= '0;
      set_cnt   <= '0;
      retry     <= '0;
      clr_cnt   <= 1'b0;
      samp_a    <= '0;
      ovf       <= 1'b0;
      msb_s1    <= 1'b0;
      msb_s2    <= 1'b0;
      msb_s3    <= 1'b0;
    end else begin
      // The chain is flushed while the counter is held clear so the MSB drop
      // caused by clearing a previous count is not mistaken for a wrap.
      if (state == ST_CLEAR) begin
        msb_s1 <= 1'b0;
        msb_s2 <= 1'b0;
        msb_s3 <= 1'b0;
      end else begin
        msb_s1 <= ctr_count[WIDTH-1];
        msb_s2 <= msb_s1;
        msb_s3 <= msb_s2;
      end
      if ((state == ST_GATE || state == ST_SETTLE) && msb_s3 && !msb_s2)
        ovf <= 1'b1;

      case (state)
        ST_IDLE: begin
          ctr_clr <= 1'b0;
          if (start) begin
            win_len <= window_len;
            clr_cnt <= 1'b0;
            ctr_clr <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          ovf   <= 1'b0;
          retry <= '0;
          if (!clr_cnt) begin
            clr_cnt <= 1'b1;
          end else begin
            ctr_clr <= 1'b0;
            win_cnt <= win_len;
            set_cnt <= SW'(SETTLE);
            if (win_len == '0) begin
              state <= ST_SETTLE;
            end else begin
              gate_en <= 1'b1;
              state   <= ST_GATE;
            end
          end
        end
        ST_GATE: begin
          if (win_cnt <= WIN_W'(1)) begin
            gate_en <= 1'b0;
            state   <= ST_SETTLE;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        ST_SETTLE: begin
          if (set_cnt <= SW'(1)) state <= ST_SAMP_A;
          else                   set_cnt <= set_cnt - SW'(1);
        end
        ST_SAMP_A: begin
          samp_a <= ctr_count;
          state  <= ST_SAMP_B;
        end
        ST_SAMP_B: begin
          if (samp_a == ctr_count) begin
            res_count <= ctr_count;
            res_ovf   <= ovf;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (retry < RW'(MAX_RETRY)) begin
            retry <= retry + RW'(1);
            state <= ST_SAMP_A;
          end else begin
            res_count <= ctr_count;
            res_ovf   <= ovf;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

`ifdef RIPPLE_CTRL_ABORT_EN
      // Abort wins over whatever the active measurement state decided this cycle.
      if (abort && state != ST_IDLE && state != ST_DONE) begin
        gate_en   <= 1'b0;
        ctr_clr   <= 1'b0;
        res_count <= '0;
        res_ovf   <= 1'b0;
        res_err   <= 1'b1;
        res_valid <= 1'b1;
        state     <= ST_DONE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Bench for ripple_count_ctrl: ripple-counter model with 2-cycle delay, scoreboard queue, random measurements.
module tb_ripple_count_ctrl;
  localparam int W         = 4;
  localparam int WIN_W     = 8;
  localparam int SETTLE    = 3;
  localparam int MAX_RETRY = 3;

  typedef struct packed {
    int           due;
    int           gate;
    logic         ovf;
    logic         err;
    logic [W-1:0] count;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic             busy, ctr_clr, gate_en, res_valid, res_ovf, res_err;
  logic [W-1:0]     ctr_count = '0;
  logic             res_ready = 1'b0;
  logic [W-1:0]     res_count;
  logic [2:0]       fsm_state;
`ifdef RIPPLE_CTRL_ABORT_EN
  logic             abort = 1'b0;
`endif

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   hold_ready = 1'b0;
  bit   noise_en = 1'b0;
  bit   pat[64];

  ripple_count_ctrl #(.WIDTH(W), .WIN_W(WIN_W), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset), .start(start), .window_len(window_len),
    .busy(busy), .ctr_clr(ctr_clr), .gate_en(gate_en), .ctr_count(ctr_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_ovf(res_ovf), .res_err(res_err),
`ifdef RIPPLE_CTRL_ABORT_EN
    .abort(abort),
`endif
    .fsm_state(fsm_state)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ripple counter model: one pulse per gated cycle when pat says so, 2-cycle output delay
  int       cnt = 0;
  int       gidx = 0;
  logic [W-1:0] d1 = '0, d2 = '0;
  always @(negedge clk) begin
    if (ctr_clr) begin
      cnt = 0; gidx = 0; d1 = '0; d2 = '0;
      ctr_count = '0;
    end else begin
      if (gate_en) begin
        if (pat[gidx]) cnt = cnt + 1;
        gidx++;
      end
      ctr_count = d2 ^ (noise_en ? W'(cyc & 1) : W'(0));
      d2 = d1;
      d1 = W'(cnt);
    end
  end

  // consumer
  always @(negedge clk) res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);

  // monitor / scoreboard
  int   gate_run = 0;
  bit   prev_valid = 1'b0;
  int   held = 0;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      gate_run = 0;
      prev_valid = 1'b0;
    end else begin
      if (gate_en) gate_run++;
      if (res_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency_cycle", cyc, e.due);
          check("res_count", int'(res_count), int'(e.count));
          check("res_ovf", int'(res_ovf), int'(e.ovf));
          check("res_err", int'(res_err), int'(e.err));
          check("gate_cycles", gate_run, e.gate);
        end
        gate_run = 0;
        held = int'({res_count, res_ovf, res_err});
      end else if (res_valid) begin
        check("result_hold", int'({res_count, res_ovf, res_err}), held);
      end
      prev_valid = res_valid;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy && exp_q.size() == 0) return;
      @(negedge clk);
    end
    check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int wl, input bit all, input bit noisy, input bit push, output int cs);
    int   sum;
    int   lat;
    bit   p;
    exp_t x;
    sum = 0;
    for (int i = 0; i < 64; i++) pat[i] = 1'b0;
    for (int i = 0; i < wl; i++) begin
      p = all ? 1'b1 : 1'(($urandom_range(0, 1)));
      // keep wraps away from the last two gated cycles so they are seen before sampling
      if (i >= wl - 2 && (sum % 16) == 15) p = 1'b0;
      pat[i] = p;
      sum += int'(p);
    end
    @(negedge clk);
    noise_en = noisy;
    window_len = WIN_W'(wl);
    start = 1'b1;
    @(posedge clk);
    #1;
    cs = cyc;
    start = 1'b0;
    window_len = WIN_W'($urandom);
    lat = 2 + wl + SETTLE + 2 + (noisy ? 2 * MAX_RETRY : 0);
    x.due   = cs + lat;
    x.gate  = wl;
    x.ovf   = (sum >= 16);
    x.err   = noisy;
    x.count = W'(sum % 16) ^ (noisy ? W'((cs + lat - 1) & 1) : W'(0));
    if (push) exp_q.push_back(x);
  endtask

  task automatic run_meas(input int wl, input bit all, input bit noisy);
    int cs;
    wait_idle();
    issue(wl, all, noisy, 1'b1, cs);
    wait_idle();
  endtask

  initial begin
    int cs;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ctr_clr", int'(ctr_clr), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_gate_en", int'(gate_en), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_flags", int'({res_count, res_ovf, res_err}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ctr_clr", int'(ctr_clr), 0);
    check("idle_busy", int'(busy), 0);

    // directed measurements
    run_meas(5, 1'b1, 1'b0);
    run_meas(20, 1'b1, 1'b0);
    run_meas(1, 1'b1, 1'b0);
    run_meas(5, 1'b1, 1'b1);

    // window 0 with result held in DONE and a start dropped there
    wait_idle();
    hold_ready = 1'b1;
    issue(0, 1'b1, 1'b0, 1'b1, cs);
    for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
    check("done_reached", int'(res_valid), 1);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      window_len = 8'd5;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_held_valid", int'(res_valid), 1);
    hold_ready = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("start_in_done_ignored", int'(busy), 0);

    // reset in the third gate cycle
    wait_idle();
    issue(8, 1'b1, 1'b0, 1'b0, cs);
    while (cyc < cs + 4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_gate_en", int'(gate_en), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(res_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_meas(2, 1'b1, 1'b0);

`ifdef RIPPLE_CTRL_ABORT_EN
    begin
      exp_t x;
      wait_idle();
      issue(8, 1'b1, 1'b0, 1'b0, cs);
      x.due = cs + 5; x.gate = 3; x.ovf = 1'b0; x.err = 1'b1; x.count = '0;
      exp_q.push_back(x);
      while (cyc < cs + 4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle();
    end
`endif

    // randomized measurements
    for (int n = 0; n < 30; n++)
      run_meas($urandom_range(0, 40), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
